// File: rtl/blink_pkg.sv
// Shared types and constants for the blink_ctrl LED driver.
// The PWM stage is compiled in only when BLINK_PWM_EN is defined.
package blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } blink_mode_t;

  localparam int PWM_W = 8;

  // Level the channel output takes on the edge that enters a new mode.
  function automatic logic entry_level(input blink_mode_t m);
    return (m == MODE_ON) || (m == MODE_BLINK);
  endfunction

endpackage

// File: rtl/blink_ctrl_if.sv
// Control/status bundle between the FPGA top level and blink_ctrl.
// Channel i occupies slice i of every packed vector.
interface blink_ctrl_if
  import blink_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int PER_W = 16
);

  logic [2*NCH-1:0]     mode;
  logic [PER_W*NCH-1:0] period;
  logic [NCH-1:0]       trig;
  logic [PWM_W*NCH-1:0] duty;
  logic [NCH-1:0]       led;
  logic [NCH-1:0]       busy;
  logic                 tick;

  modport master (
    output mode,
    output period,
    output trig,
    output duty,
    input  led,
    input  busy,
    input  tick
  );

  modport slave (
    input  mode,
    input  period,
    input  trig,
    input  duty,
    output led,
    output busy,
    output tick
  );

endinterface

// File: rtl/blink_chan.sv
// One indicator channel: mode register, tick counter, on/busy state and,
// when BLINK_PWM_EN is defined, a registered PWM dimming gate on the output.
module blink_chan
  import blink_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [PWM_W-1:0]  pwm_cnt,
  input  blink_mode_t       mode,
  input  logic [PER_W-1:0]  period,
  input  logic              trig,
  input  logic [PWM_W-1:0]  duty,
  output logic              led,
  output logic              busy
);

  // A zero period behaves as one tick so the channel never stalls.
  function automatic logic [PER_W-1:0] eff_period(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_W'(1) : p;
  endfunction

  blink_mode_t      cur_mode;
  logic [PER_W-1:0] cnt;
  logic             on;
  logic [PER_W-1:0] pe_m1;
  logic             expired;

  assign pe_m1   = eff_period(period) - PER_W'(1);
  // >= rather than == so a period shrunk below cnt ends the phase at the next tick.
  assign expired = (cnt >= pe_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_mode <= MODE_OFF;
      cnt      <= '0;
      on       <= 1'b0;
      busy     <= 1'b0;
    end else if (mode != cur_mode) begin
      cur_mode <= mode;
      cnt      <= '0;
      busy     <= 1'b0;
      on       <= entry_level(mode);
    end else begin
      unique case (cur_mode)
        MODE_OFF: begin
          on  <= 1'b0;
          cnt <= '0;
        end
        MODE_ON: begin
          on  <= 1'b1;
          cnt <= '0;
        end
        MODE_BLINK: begin
          if (tick) begin
            if (expired) begin
              on  <= ~on;
              cnt <= '0;
            end else begin
              cnt <= cnt + PER_W'(1);
            end
          end
        end
        MODE_ONESHOT: begin
          // A trigger always restarts the pulse, even on the terminating tick.
          if (trig) begin
            on   <= 1'b1;
            busy <= 1'b1;
            cnt  <= '0;
          end else if (busy && tick) begin
            if (expired) begin
              on   <= 1'b0;
              busy <= 1'b0;
            end else begin
              cnt <= cnt + PER_W'(1);
            end
          end
        end
        default: begin
          on  <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef BLINK_PWM_EN
  logic pwm_pass;
  logic led_q;

  assign pwm_pass = (duty == '1) || (pwm_cnt < duty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q <= 1'b0;
    end else begin
      led_q <= on & pwm_pass;
    end
  end

  assign led = led_q;
`else
  logic unused_pwm;
  assign unused_pwm = ^{pwm_cnt, duty};
  assign led        = on;
`endif

endmodule

// File: rtl/blink_ctrl.sv
// Multi-channel LED driver: shared tick prescaler, NCH blink_chan instances and,
// with BLINK_PWM_EN defined, a shared free-running PWM counter.
module blink_ctrl
  import blink_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  blink_ctrl_if.slave bus
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              tick_q;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [NCH-1:0]    led_w;
  logic [NCH-1:0]    busy_w;

  // Free-running prescaler; channel activity never restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt   <= '0;
      tick_q <= 1'b0;
    end else begin
      pcnt   <= (pcnt == PCNT_LAST) ? '0 : pcnt + PCNT_W'(1);
      tick_q <= (pcnt == PCNT_LAST);
    end
  end

`ifdef BLINK_PWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
    end
  end
`else
  assign pwm_cnt = '0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    blink_chan #(
      .PER_W (PER_W)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick_q),
      .pwm_cnt (pwm_cnt),
      .mode    (blink_mode_t'(bus.mode[2*i +: 2])),
      .period  (bus.period[PER_W*i +: PER_W]),
      .trig    (bus.trig[i]),
      .duty    (bus.duty[PWM_W*i +: PWM_W]),
      .led     (led_w[i]),
      .busy    (busy_w[i])
    );
  end

  assign bus.led  = led_w;
  assign bus.busy = busy_w;
  assign bus.tick = tick_q;

endmodule

// File: doc/blink_ctrl.md
# blink_ctrl

Multi-channel, parametrised LED/indicator driver for the FPGA top level. It replaces the hand-written per-clock divide-to-1 Hz counters. A shared prescaler derives a tick from the system clock, and NCH independent channels each run in OFF, ON, BLINK or ONESHOT mode with a runtime-programmable period. An optional PWM dimming stage can be compiled in. It sits in the `wshb_clk` domain and drives the board LEDs directly.

## Interface
- `NCH`, 4: number of channels (1..16)
- `CLK_HZ`, 50_000_000: frequency of `clk` in Hz
- `TICK_HZ`, 1000: prescaler tick rate; `TICK_DIV = CLK_HZ/TICK_HZ`, which must be ≥ 2
- `PER_W`, 16: width of each per-channel period field, counted in ticks
- `clk` in 1: system clock
- `rst` in 1: reset. **Asynchronous, active-high; the only clock is `clk`.**
- `mode` in 2*NCH: per-channel mode; channel i uses bits [2i+1:2i]
- `period` in PER_W*NCH: per-channel half-period (BLINK) or pulse length (ONESHOT), in ticks
- `trig` in NCH: per-channel one-shot trigger, level-sampled
- `duty` in 8*NCH: per-channel PWM duty; ignored unless `BLINK_PWM_EN` is defined
- `led` out NCH: channel outputs, registered
- `busy` out NCH: high while a one-shot pulse is running
- `tick` out 1: one-cycle prescaler strobe

## Operation
- **Prescaler:** `pcnt` counts 0..TICK_DIV-1 and wraps. `tick` is 1 for exactly one cycle each time `pcnt` == TICK_DIV-1. The prescaler is free-running and never restarted by channel activity.
- **Channel state:** each channel registers its mode (`cur_mode`), a count `cnt` [PER_W-1:0] and a logical state `on`. The effective period is `pe = (period==0) ? 1 : period`.
- **Mode change:** when `mode` differs from `cur_mode`, the next edge loads `cur_mode` and clears `cnt` and `busy`. `on` is then forced per mode: OFF=0, ON=1, BLINK=1, ONESHOT=0.
- **OFF (00) / ON (01):** `on` is held at 0 or 1. `cnt` is held at 0.
- **BLINK (10):**
  - On `tick`: if `cnt >= pe-1`, then `on` toggles and `cnt` clears; else `cnt++`.
  - The `>=` compare makes a mid-run period decrease take effect at the next tick, with no wrap-around of `cnt`.
- **ONESHOT (11):**
  - `trig`=1 at an edge loads `on`=1, `busy`=1 and `cnt`=0. This applies whether the channel is idle or busy, so a retrigger restarts the pulse.
  - While busy, each `tick` checks `cnt >= pe-1`: if true, `on`=0 and `busy`=0; else `cnt++`.
  - If `trig` is high on the same edge as the terminating tick, `trig` wins and the pulse restarts.
- **Output:** `led[i] = on[i]`, registered. With `BLINK_PWM_EN` defined, the PWM stage below applies.
- **Reset:** `led`=0, `busy`=0, `tick`=0, `pcnt`=0, all `cnt`=0, `on`=0, `cur_mode`=OFF. Assertion mid-operation aborts everything immediately. After release, any mode other than OFF is applied as a mode change on the first edge.

## Timing
- `mode` change to `led` update: 1 cycle.
- `trig` to `led`/`busy` high: 1 cycle.
- Pulse length is between pe-1 and pe full tick periods plus the sub-tick phase, because the prescaler is not aligned to `trig`.
- BLINK full period: 2*pe ticks. The first half-period after mode entry has the same phase uncertainty as a one-shot pulse.
- `period` and `duty` are sampled every cycle. There is no shadow register.

## Configuration
- Macro: `BLINK_PWM_EN`.
- **Defined:**
  - A shared 8-bit free-running counter `pwm_cnt`, clocked by `clk` and reset to 0, is added.
  - `led[i] = on[i] & (duty[i]==255 | pwm_cnt < duty[i])`, registered, which adds 1 cycle of output latency.
  - `duty`=0 forces the LED dark while `busy` still behaves normally.
- **Undefined:** no PWM logic is built, the `duty` port is left unused, and `led = on`.

## Structure
- Package `blink_pkg`:
  - `typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_ONESHOT} blink_mode_t`
  - `localparam PWM_W = 8`
- Sub-module `blink_chan`: a single channel containing `cur_mode`, `cnt`, `on`, `busy` and the optional PWM gate.
  - Takes `tick` and `pwm_cnt` as inputs.
  - The top level holds the prescaler and the PWM counter, and instantiates `blink_chan` NCH times in a generate loop.

## Test plan
All scenarios use `CLK_HZ`=100 and `TICK_HZ`=10, giving `TICK_DIV`=10.
1. **Reset and prescaler:** hold `rst` for 3 cycles, then release. `led`=0 and `busy`=0 throughout. `tick` pulses 1 cycle every 10 cycles, first at the 10th edge after release.
2. **BLINK:** ch0 set to BLINK with `period`=3. `led[0]` rises 1 cycle after the mode change, then toggles every 30 cycles in steady state. Forcing `period`=0 gives a toggle every tick (10 cycles).
3. **Period shrink:** during BLINK with `period`=100, after `cnt`=50 write `period`=5. The toggle occurs on the next tick and `cnt` returns to 0 with no wrap.
4. **ONESHOT:** ch1 in ONESHOT with `period`=4 and a 1-cycle `trig`. `busy[1]` and `led[1]` go high 1 cycle later and drop after 31..40 cycles. A retrigger mid-pulse extends the pulse, and `trig` coincident with the terminating tick keeps `busy`=1.
5. **Mode abort / async reset:** switching ch1 to OFF while busy drops `led` and `busy` after 1 cycle. Asserting `rst` mid-pulse clears the outputs with no clock edge.
6. **`BLINK_PWM_EN`:** ch2 set to ON:
   - `duty`=64 gives `led[2]` high 64 of every 256 cycles.
   - `duty`=255 holds `led[2]` constant high.
   - `duty`=0 holds `led[2]` constant low.
